// File: rtl/cpu_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : cpu_bus_arb
// Shares the CPU bus among the 6502 core, debug block and sprite DMA engine;
// optional grant watchdog enabled by defining CPU_BUS_ARB_WDOG_EN.
// Revision : 1.0
// ============================================================================
module cpu_bus_arb
`ifdef CPU_BUS_ARB_WDOG_EN
  #(parameter int unsigned WDOG_CYCLES = 65536)
`endif
  (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] core_a,
  input  logic [7:0]  core_dout,
  input  logic        core_r_nw,
  output logic        core_rdy,
  input  logic        dbg_req,
  input  logic [15:0] dbg_a,
  input  logic [7:0]  dbg_dout,
  input  logic        dbg_r_nw,
  output logic        dbg_gnt,
  input  logic        dma_req,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_dout,
  input  logic        dma_r_nw,
  output logic        dma_gnt,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_r_nw,
  output logic        arb_err
);

  typedef enum logic [2:0] {
    S_CORE      = 3'd0,
    S_HALT_WAIT = 3'd1,
    S_DBG       = 3'd2,
    S_DMA       = 3'd3,
    S_TURN      = 3'd4
  } state_t;

  state_t      state_q;
  logic        core_rdy_q;
  logic        dbg_gnt_q;
  logic        dma_gnt_q;
  logic [15:0] hold_a_q;
  logic [7:0]  hold_d_q;
  logic        dbg_req_ok;
  logic        dma_req_ok;
  logic        any_req;
  logic        wdog_hit;

`ifdef CPU_BUS_ARB_WDOG_EN
  logic [16:0] wdog_q;
  logic        dbg_blk_q;
  logic        dma_blk_q;
  logic        arb_err_q;

  // A revoked master stays masked until it lets go of its request.
  assign dbg_req_ok = dbg_req & ~dbg_blk_q;
  assign dma_req_ok = dma_req & ~dma_blk_q;
  assign wdog_hit   = (dbg_gnt_q | dma_gnt_q) && (wdog_q == 17'(WDOG_CYCLES - 1));
  assign arb_err    = arb_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q    <= '0;
      dbg_blk_q <= 1'b0;
      dma_blk_q <= 1'b0;
      arb_err_q <= 1'b0;
    end else begin
      wdog_q    <= ((dbg_gnt_q | dma_gnt_q) && !wdog_hit) ? wdog_q + 17'd1 : '0;
      arb_err_q <= wdog_hit;
      if (wdog_hit && dbg_gnt_q) dbg_blk_q <= 1'b1;
      else if (!dbg_req)         dbg_blk_q <= 1'b0;
      if (wdog_hit && dma_gnt_q) dma_blk_q <= 1'b1;
      else if (!dma_req)         dma_blk_q <= 1'b0;
    end
  end
`else
  assign dbg_req_ok = dbg_req;
  assign dma_req_ok = dma_req;
  assign wdog_hit   = 1'b0;
  assign arb_err    = 1'b0;
`endif

  assign any_req  = dbg_req_ok | dma_req_ok;
  assign core_rdy = core_rdy_q;
  assign dbg_gnt  = dbg_gnt_q;
  assign dma_gnt  = dma_gnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CORE;
      core_rdy_q <= 1'b1;
      dbg_gnt_q  <= 1'b0;
      dma_gnt_q  <= 1'b0;
    end else begin
      case (state_q)
        S_CORE: begin
          if (any_req) begin
            core_rdy_q <= 1'b0;
            state_q    <= S_HALT_WAIT;
          end
        end
        S_HALT_WAIT: begin
          // The core only honours RDY on a read, so wait for one before handing over.
          if (!any_req) begin
            core_rdy_q <= 1'b1;
            state_q    <= S_CORE;
          end else if (core_r_nw) begin
            if (dbg_req_ok) begin
              dbg_gnt_q <= 1'b1;
              state_q   <= S_DBG;
            end else begin
              dma_gnt_q <= 1'b1;
              state_q   <= S_DMA;
            end
          end
        end
        S_DBG: begin
          if (wdog_hit || !dbg_req) begin
            dbg_gnt_q <= 1'b0;
            state_q   <= S_TURN;
          end
        end
        S_DMA: begin
          if (wdog_hit || !dma_req) begin
            dma_gnt_q <= 1'b0;
            state_q   <= S_TURN;
          end
        end
        S_TURN: begin
          if (dbg_req_ok) begin
            dbg_gnt_q <= 1'b1;
            state_q   <= S_DBG;
          end else if (dma_req_ok) begin
            dma_gnt_q <= 1'b1;
            state_q   <= S_DMA;
          end else begin
            core_rdy_q <= 1'b1;
            state_q    <= S_CORE;
          end
        end
        default: begin
          state_q    <= S_CORE;
          core_rdy_q <= 1'b1;
          dbg_gnt_q  <= 1'b0;
          dma_gnt_q  <= 1'b0;
        end
      endcase
    end
  end

  // Last driven bus value, replayed during the turnaround cycle.
  always_ff @(posedge clk) begin
    hold_a_q <= mem_a;
    hold_d_q <= mem_dout;
  end

  always_comb begin
    mem_a    = core_a;
    mem_dout = core_dout;
    mem_r_nw = core_r_nw;
    case (state_q)
      S_DBG: begin
        mem_a    = dbg_a;
        mem_dout = dbg_dout;
        mem_r_nw = dbg_r_nw;
      end
      S_DMA: begin
        mem_a    = dma_a;
        mem_dout = dma_dout;
        mem_r_nw = dma_r_nw;
      end
      S_TURN: begin
        mem_a    = hold_a_q;
        mem_dout = hold_d_q;
        mem_r_nw = 1'b1;
      end
      default: ;
    endcase
    if (rst) mem_r_nw = 1'b1;
  end

endmodule
`default_nettype wire
